imem_loader: RTL and testbench

- Writer side of the instruction-memory read path: receives a program as a byte stream and writes it word by word into instruction memory.
- The processor fetches from instruction memory using only pc_out; this block fills that memory before execution starts.
- Sits between a host byte source and the instruction memory's write port.
- Holds the processor's program counter in clear until the load completes.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader_byte_packer.sv | 54 +++++
 rtl/imem_loader.sv | 108 ++++++++++
 tb/tb_imem_loader.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the byte/word geometry of the incoming program stream.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream, load control/status and instruction-memory write port
// of the loader, bundled so the host side and the loader share one view.
interface imem_loader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);

  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  modport master (
    output start, word_count, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
  );

  modport slave (
    input  start, word_count, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes big-endian into one instruction word. The word output
// already includes the byte being accepted this cycle, so the word can be
// registered on the same edge that takes the last byte.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = BYTES_PER_WORD * BYTE_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_data,
  output logic [DATA_W-1:0] word,
  output logic              word_full
);

  logic [1:0]        cnt;
  logic [DATA_W-1:0] shreg;

  assign word_full = accept && (cnt == 2'(BYTES_PER_WORD - 1));

  // Merge the incoming byte into its big-endian lane of the held word
  always_comb begin
    word = shreg;
    if (accept) begin
      case (cnt)
        2'd0:    word[DATA_W-1  -: BYTE_W] = byte_data;
        2'd1:    word[DATA_W-9  -: BYTE_W] = byte_data;
        2'd2:    word[DATA_W-17 -: BYTE_W] = byte_data;
        default: word[DATA_W-25 -: BYTE_W] = byte_data;
      endcase
    end
  end

  // Byte position counter; cleared at word boundaries and load start
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 2'd1;
    end
  end

  // Word holding register; every lane is rewritten before use, so no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a program as a byte stream, writes it
// word by word into instruction memory and holds the processor's PC in clear
// until the whole program is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         clr,
  imem_loader_if.slave bus
);

  // Largest loadable program: exactly fills the address space
  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nxt;
  logic [ADDR_W:0]   index, count, index_inc;
  logic              ready, accept, load, err_set, err_clr, pack_clear;
  logic              word_full;
  logic [DATA_W-1:0] word;

  assign ready          = (state == RECV);
  assign accept         = ready && bus.byte_valid;
  assign index_inc      = index + (ADDR_W+1)'(1);
  assign pack_clear     = load || (state == WRITE);
  assign bus.byte_ready = ready;

  imem_loader_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk       (clk),
    .clr       (clr),
    .clear     (pack_clear),
    .accept    (accept),
    .byte_data (bus.byte_data),
    .word      (word),
    .word_full (word_full)
  );

  // Next-state decode and load-control strobes
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          if (bus.word_count == '0) begin
            state_nxt = DONE;
            err_clr   = 1'b1;
          end else if (bus.word_count > MAX_WORDS) begin
            state_nxt = IDLE;
            err_set   = 1'b1;
          end else begin
            state_nxt = RECV;
            load      = 1'b1;
            err_clr   = 1'b1;
          end
        end
      end
      RECV: begin
        if (word_full) state_nxt = WRITE;
      end
      WRITE: begin
        state_nxt = (index_inc == count) ? DONE : RECV;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Registered outputs follow the state being entered; word index/count
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      index          <= '0;
      count          <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.cpu_hold   <= 1'b1;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      if (load) begin
        count <= bus.word_count;
        index <= '0;
      end else if (state == WRITE) begin
        index <= index_inc;
      end
      if (err_set)      bus.err <= 1'b1;
      else if (err_clr) bus.err <= 1'b0;
      bus.imem_we  <= (state_nxt == WRITE);
      bus.done     <= (state_nxt == DONE);
      bus.cpu_hold <= (state_nxt != DONE);
      if (state_nxt == WRITE) begin
        bus.imem_addr  <= index[ADDR_W-1:0];
        bus.imem_wdata <= word;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed scenarios with random program contents and
// random byte-valid gaps, checked against a word-list model of the program.
module tb_imem_loader;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Observed memory writes and handshake activity
  logic [ADDR_W-1:0] wa_q[$];
  logic [DATA_W-1:0] wd_q[$];
  int                acc_cnt      = 0;
  int                rdy_in_write = 0;
  logic [7:0]        byte_q[$];

  always @(posedge clk) begin
    if (bus.imem_we) begin
      wa_q.push_back(bus.imem_addr);
      wd_q.push_back(bus.imem_wdata);
      if (bus.byte_ready) rdy_in_write++;
    end
    if (bus.byte_valid && bus.byte_ready) acc_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int wc);
    bus.start      = 1'b1;
    bus.word_count = 7'(wc);
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  // Offer byte_q to the loader; mode 0 back-to-back, 1 toggling, 2 random.
  // With poke set, a start with a different count is pulsed mid-word.
  task automatic feed(input int mode, input bit poke, input string tag);
    int p = 0;
    int guard = 0;
    bit v, rdy;
    bit poked = 1'b0;
    bit tog = 1'b0;
    while (p < byte_q.size() && guard < 2000) begin
      bus.start = 1'b0;
      if (poke && p == 1 && !poked) begin
        bus.start      = 1'b1;
        bus.word_count = 7'd7;
        poked          = 1'b1;
      end
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = ~tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.byte_valid = v;
      bus.byte_data  = v ? byte_q[p] : 8'($urandom);
      rdy = bus.byte_ready;
      @(negedge clk);
      if (v && rdy) p++;
      guard++;
    end
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    check({tag, "_bytes_taken"}, 64'(p), 64'(byte_q.size()));
  endtask

  task automatic wait_done(input string tag);
    int g = 0;
    while (!bus.done && g < 50) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_done"}, 64'(bus.done), 64'(1));
  endtask

  // Load n random words and compare the write log with the program
  task automatic run_load(input int n, input int mode, input bit poke, input string tag);
    int base, acc0;
    logic [31:0] exp_w[$];
    logic [31:0] w;
    base = wa_q.size();
    acc0 = acc_cnt;
    byte_q.delete();
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      exp_w.push_back(w);
      for (int k = 0; k < 4; k++) byte_q.push_back(w[31-8*k -: 8]);
    end
    pulse_start(n);
    check({tag, "_hold_on_start"}, 64'(bus.cpu_hold), 64'(1));
    check({tag, "_done_cleared"},  64'(bus.done), 64'(0));
    check({tag, "_ready_in_recv"}, 64'(bus.byte_ready), 64'(1));
    check({tag, "_err_cleared"},   64'(bus.err), 64'(0));
    feed(mode, poke, tag);
    wait_done(tag);
    check({tag, "_hold_released"}, 64'(bus.cpu_hold), 64'(0));
    check({tag, "_write_count"}, 64'(wa_q.size() - base), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < wa_q.size()) begin
        check($sformatf("%s_addr%0d", tag, i), 64'(wa_q[base+i]), 64'(i));
        check($sformatf("%s_data%0d", tag, i), 64'(wd_q[base+i]), 64'(exp_w[i]));
      end
    end
    check({tag, "_accepted"}, 64'(acc_cnt - acc0), 64'(4 * n));
  endtask

  initial begin
    int base;
    logic [31:0] first_w;
    logic [7:0]  dir_bytes[4];

    clr            = 1'b1;
    bus.start      = 1'b0;
    bus.word_count = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;

    // Reset held for two cycles
    @(negedge clk);
    @(negedge clk);
    check("rst_cpu_hold",   64'(bus.cpu_hold), 64'(1));
    check("rst_done",       64'(bus.done), 64'(0));
    check("rst_byte_ready", 64'(bus.byte_ready), 64'(0));
    check("rst_imem_we",    64'(bus.imem_we), 64'(0));
    check("rst_err",        64'(bus.err), 64'(0));
    check("rst_addr",       64'(bus.imem_addr), 64'(0));
    check("rst_wdata",      64'(bus.imem_wdata), 64'(0));
    clr = 1'b0;
    @(negedge clk);
    check("idle_hold", 64'(bus.cpu_hold), 64'(1));

    // Single directed word, bytes back-to-back
    dir_bytes[0] = 8'h8C; dir_bytes[1] = 8'h01; dir_bytes[2] = 8'h00; dir_bytes[3] = 8'h04;
    base = wa_q.size();
    pulse_start(1);
    check("one_ready", 64'(bus.byte_ready), 64'(1));
    for (int k = 0; k < 4; k++) begin
      bus.byte_valid = 1'b1;
      bus.byte_data  = dir_bytes[k];
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
    check("one_we",        64'(bus.imem_we), 64'(1));
    check("one_addr",      64'(bus.imem_addr), 64'(0));
    check("one_wdata",     64'(bus.imem_wdata), 64'h8C010004);
    check("one_ready_wr",  64'(bus.byte_ready), 64'(0));
    check("one_done_early",64'(bus.done), 64'(0));
    @(negedge clk);
    check("one_done",      64'(bus.done), 64'(1));
    check("one_hold",      64'(bus.cpu_hold), 64'(0));
    check("one_we_off",    64'(bus.imem_we), 64'(0));
    check("one_nwrites",   64'(wa_q.size() - base), 64'(1));

    // Three words with toggling byte_valid, started from DONE
    run_load(3, 1, 1'b0, "three");

    // Start pulsed during RECV must not change the count
    run_load(2, 2, 1'b1, "poke");

    // Zero-length program from IDLE
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    base = wa_q.size();
    pulse_start(0);
    check("zero_done", 64'(bus.done), 64'(1));
    check("zero_hold", 64'(bus.cpu_hold), 64'(0));
    check("zero_err",  64'(bus.err), 64'(0));
    @(negedge clk);
    @(negedge clk);
    check("zero_nwrites", 64'(wa_q.size() - base), 64'(0));

    // Out-of-range count from IDLE
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    pulse_start(65);
    check("big_err",   64'(bus.err), 64'(1));
    check("big_hold",  64'(bus.cpu_hold), 64'(1));
    check("big_done",  64'(bus.done), 64'(0));
    check("big_ready", 64'(bus.byte_ready), 64'(0));
    @(negedge clk);
    check("big_stay_idle", 64'(bus.byte_ready), 64'(0));
    check("big_err_held",  64'(bus.err), 64'(1));

    // Full memory, random gaps
    run_load(64, 2, 1'b0, "full");
    check("full_last_addr", 64'(wa_q[wa_q.size()-1]), 64'(63));

    // Reset in the middle of the second word
    base = wa_q.size();
    first_w = $urandom;
    byte_q.delete();
    for (int k = 0; k < 4; k++) byte_q.push_back(first_w[31-8*k -: 8]);
    byte_q.push_back(8'($urandom));
    byte_q.push_back(8'($urandom));
    pulse_start(2);
    feed(0, 1'b0, "clrmid");
    check("clrmid_nwrites", 64'(wa_q.size() - base), 64'(1));
    if (wd_q.size() > base) check("clrmid_word0", 64'(wd_q[base]), 64'(first_w));
    #2 clr = 1'b1;
    #1;
    check("clrmid_hold",  64'(bus.cpu_hold), 64'(1));
    check("clrmid_ready", 64'(bus.byte_ready), 64'(0));
    check("clrmid_done",  64'(bus.done), 64'(0));
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    run_load(1, 0, 1'b0, "fresh");

    check("ready_never_in_write", 64'(rdy_in_write), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
